// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Mult/div occupancy state: RUN while the counter is zero, MD_WAIT otherwise.
  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // MIPS $zero: never a real producer, so never a hazard source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default busy time of the mult/div unit and the counter width that covers 1..15.
  localparam int MD_LATENCY_DEF = 4;
  localparam int MD_CNT_W       = 4;

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: accepts a start and counts the unit's busy cycles down.
// Latency: md_busy rises the cycle after the accepting edge, high for MD_LATENCY cycles.
// Backpressure: a start is only taken when idle, not stalled and not squashed by a branch.
module md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic md_start,
  input  logic stall,
  input  logic branch_taken,
  output logic md_busy,
  output logic md_accept
);

  md_state_e            state_q, state_d;
  logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;

  // Next-state: load on accept, count down while waiting, return to RUN as the count hits zero.
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_accept = md_start & ~stall & ~branch_taken & (state_q == RUN);
    case (state_q)
      RUN: begin
        if (md_accept) begin
          md_cnt_d = MD_CNT_W'(MD_LATENCY);
          state_d  = MD_WAIT;
        end
      end
      MD_WAIT: begin
        md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // State register; reset aborts any in-flight count at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (state_q == MD_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use, taken-branch flush and mult/div waits for the 5-stage pipe.
// Latency: all control outputs are combinational, same cycle as the inputs.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; a taken branch overrides the stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   id_md_start,
  input  logic                   id_md_use,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_branch_taken,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic load_use;
  logic md_hold;
  logic stall;
  logic md_busy_int;
  logic md_accept;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_timer (
    .clock        (clock),
    .reset        (reset),
    .md_start     (id_md_start),
    .stall        (stall),
    .branch_taken (ex_branch_taken),
    .md_busy      (md_busy_int),
    .md_accept    (md_accept)
  );

  // Hazard detection: a load feeding an ID source, or an ID mult/div access while the unit is busy.
  always_comb begin
    load_use = ex_mem_read & (ex_rt != REG_ZERO) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    md_hold  = md_busy_int & (id_md_start | id_md_use);
    stall    = load_use | md_hold;
  end

  // Pipeline control: reset holds a flushed pipe, then branch beats stall beats normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Stall-cycle counter: counts only stalls that actually hold the pipe, saturating at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !ex_branch_taken && (stall_cycles_q != {STALL_CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_busy      = md_busy_int;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand sequences, randomized run vs reference model.
// Latency: outputs checked 1 time unit after inputs change, well before the next rising edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_md_start, id_md_use, ex_mem_read, ex_branch_taken;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_md_busy;
  logic [3:0]  s_stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   busy_left;
  int   cnt16, cnt4;
  logic m_stall, m_busy;
  logic [3:0] m_ctl; // {pc_write, if_id_write, if_id_flush, id_ex_bubble}

  hazard_ctrl #(.MD_LATENCY(LAT), .STALL_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_use(id_md_use), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MD_LATENCY(LAT), .STALL_CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_use(id_md_use), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .md_busy(s_md_busy),
    .stall_cycles(s_stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected outputs from the hazard rules; reset clears everything asynchronously.
  task automatic model_comb();
    logic lu;
    if (reset) begin
      busy_left = 0;
      cnt16 = 0;
      cnt4 = 0;
    end
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    m_busy  = (busy_left > 0);
    m_stall = lu || (m_busy && (id_md_start || id_md_use));
    if (reset)                m_ctl = 4'b0011;
    else if (ex_branch_taken) m_ctl = 4'b1111;
    else if (m_stall)         m_ctl = 4'b0001;
    else                      m_ctl = 4'b1100;
  endtask

  // Clock-edge behaviour of the model using the inputs held across the edge.
  task automatic model_edge();
    if (!reset) begin
      if (m_stall && !ex_branch_taken) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (busy_left > 0) busy_left--;
      else if (id_md_start && !m_stall && !ex_branch_taken) busy_left = LAT;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctl"}, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, m_ctl});
    chk({tag, ".busy"}, {31'd0, md_busy}, {31'd0, m_busy});
    chk({tag, ".cnt"}, {16'd0, stall_cycles}, cnt16);
    chk({tag, ".cnt4"}, {28'd0, s_stall_cycles}, cnt4);
    chk({tag, ".s_ctl"}, {28'd0, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble},
        {28'd0, m_ctl});
  endtask

  // One cycle: inputs already driven after a falling edge; check, take the edge, return at next fall.
  task automatic cyc(input string tag);
    #1;
    model_comb();
    check_all(tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_md_start = 1'b0; id_md_use = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs, rt, xrt;
    logic       uses_rt, md_start, md_use, mem_read, br;
    logic [3:0] exp_ctl;
  } vec_t;

  vec_t vecs[11];

  initial begin
    //                rs     rt     xrt   urt mds mdu mr  br   {pc,ifid,flush,bub}
    vecs[0]  = '{5'd8,  5'd0,  5'd8,  1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0001}; // load-use via rs
    vecs[1]  = '{5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1100}; // $zero guard
    vecs[2]  = '{5'd3,  5'd9,  5'd9,  1'b1,1'b0,1'b0,1'b1,1'b0, 4'b0001}; // load-use via rt
    vecs[3]  = '{5'd3,  5'd9,  5'd9,  1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1100}; // rt not a source
    vecs[4]  = '{5'd8,  5'd0,  5'd8,  1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100}; // not a load
    vecs[5]  = '{5'd8,  5'd0,  5'd8,  1'b0,1'b0,1'b0,1'b1,1'b1, 4'b1111}; // branch over stall
    vecs[6]  = '{5'd1,  5'd2,  5'd5,  1'b1,1'b0,1'b0,1'b0,1'b1, 4'b1111}; // branch alone
    vecs[7]  = '{5'd4,  5'd0,  5'd0,  1'b1,1'b0,1'b0,1'b1,1'b0, 4'b1100}; // rt=$zero guard
    vecs[8]  = '{5'd1,  5'd2,  5'd3,  1'b1,1'b0,1'b1,1'b0,1'b0, 4'b1100}; // mflo while idle
    vecs[9]  = '{5'd1,  5'd2,  5'd3,  1'b0,1'b1,1'b0,1'b0,1'b1, 4'b1111}; // mult squashed
    vecs[10] = '{5'd7,  5'd2,  5'd7,  1'b0,1'b1,1'b0,1'b1,1'b0, 4'b0001}; // mult behind load

    idle_inputs();
    reset = 1'b1;
    busy_left = 0; cnt16 = 0; cnt4 = 0;
    @(negedge clock);
    #1;
    chk("rst.ctl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'b0011);
    chk("rst.busy", {31'd0, md_busy}, 32'd0);
    chk("rst.cnt", {16'd0, stall_cycles}, 32'd0);
    cyc("rst");
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].xrt;
      id_uses_rt = vecs[i].uses_rt; id_md_start = vecs[i].md_start; id_md_use = vecs[i].md_use;
      ex_mem_read = vecs[i].mem_read; ex_branch_taken = vecs[i].br;
      #1;
      chk($sformatf("vec%0d.ctl", i), {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble},
          {28'd0, vecs[i].exp_ctl});
      cyc($sformatf("vec%0d", i));
    end
    idle_inputs();
    #1;
    // Three load-use stalls counted above (vec0, vec2, vec10); squashed and rejected starts left md idle.
    chk("vec.cnt_total", {16'd0, stall_cycles}, 32'd3);
    chk("vec.md_idle", {31'd0, md_busy}, 32'd0);
    cyc("vec.tail");

    // Mult accepted, then mflo waits out the busy window.
    id_md_start = 1'b1;
    cyc("md.start");
    id_md_start = 1'b0; id_md_use = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      chk($sformatf("md.wait%0d.busy", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("md.wait%0d.pc", i), {31'd0, pc_write}, 32'd0);
      cyc($sformatf("md.wait%0d", i));
    end
    #1;
    chk("md.go.busy", {31'd0, md_busy}, 32'd0);
    chk("md.go.pc", {31'd0, pc_write}, 32'd1);
    cyc("md.go");

    // Back-to-back mults: second start waits and is accepted LAT+1 cycles after the first.
    idle_inputs();
    id_md_start = 1'b1;
    cyc("b2b.first");
    for (int i = 0; i < LAT; i++) cyc($sformatf("b2b.hold%0d", i));
    #1;
    chk("b2b.second_take", {31'd0, pc_write}, 32'd1);
    cyc("b2b.second");
    idle_inputs();
    #1;
    chk("b2b.busy_again", {31'd0, md_busy}, 32'd1);

    // Reset while md_cnt=2.
    for (int i = 0; i < LAT; i++) cyc($sformatf("drain%0d", i));
    id_md_start = 1'b1;
    cyc("rmid.start");
    id_md_start = 1'b0;
    cyc("rmid.c4");
    cyc("rmid.c3");
    reset = 1'b1;
    #1;
    chk("rmid.busy", {31'd0, md_busy}, 32'd0);
    chk("rmid.flush", {31'd0, if_id_flush}, 32'd1);
    chk("rmid.cnt", {16'd0, stall_cycles}, 32'd0);
    cyc("rmid.rst");
    reset = 1'b0;
    id_md_use = 1'b1;
    #1;
    chk("rmid.after.busy", {31'd0, md_busy}, 32'd0);
    chk("rmid.after.pc", {31'd0, pc_write}, 32'd1);
    cyc("rmid.after");

    // Saturation: 20 load-use stalls.
    idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i));
    idle_inputs();
    #1;
    chk("sat.cnt4", {28'd0, s_stall_cycles}, 32'd15);
    chk("sat.cnt16", {16'd0, stall_cycles}, 32'd20);
    cyc("sat.tail");

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      id_md_start = ($urandom_range(0, 3) == 0);
      id_md_use   = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      cyc($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
